// File: rtl/cmd_pkg.sv
// Shared command-frame definitions: field widths, payload byte offsets,
// the unpacked command record (also used by wcm) and the packer FSM states.
package cmd_pkg;

    localparam int PAYLOAD_BYTES = 43;
    localparam int SHADOW_W      = 8 * PAYLOAD_BYTES;
    localparam int SUM_W         = 8;
    localparam int BYTE_CNT_W    = 6;
    localparam int FRAME_CNT_W   = 16;

    // Field widths as presented on the command outputs
    localparam int FREQ_W       = 48;
    localparam int FREQ_STEP_W  = 48;
    localparam int FREQ_RATE_W  = 32;
    localparam int TIME_START_W = 64;
    localparam int N_IMPULSE_W  = 16;
    localparam int TYPE_W       = 2;
    localparam int INTERVAL_W   = 32;
    localparam int TBLANK_W     = 32;

    // Byte offsets of each field inside the 43-byte payload (MSB byte first)
    localparam int FREQ_OFS       = 0;
    localparam int FREQ_STEP_OFS  = 6;
    localparam int FREQ_RATE_OFS  = 12;
    localparam int TIME_START_OFS = 16;
    localparam int N_IMPULSE_OFS  = 24;
    localparam int TYPE_OFS       = 26;
    localparam int TI_OFS         = 27;
    localparam int TP_OFS         = 31;
    localparam int TBLANK1_OFS    = 35;
    localparam int TBLANK2_OFS    = 39;

    // Shadow bit index of the MSB of each field's first byte
    localparam int FREQ_MSB       = SHADOW_W - 1 - 8 * FREQ_OFS;
    localparam int FREQ_STEP_MSB  = SHADOW_W - 1 - 8 * FREQ_STEP_OFS;
    localparam int FREQ_RATE_MSB  = SHADOW_W - 1 - 8 * FREQ_RATE_OFS;
    localparam int TIME_START_MSB = SHADOW_W - 1 - 8 * TIME_START_OFS;
    localparam int N_IMPULSE_MSB  = SHADOW_W - 1 - 8 * N_IMPULSE_OFS;
    localparam int TYPE_MSB       = SHADOW_W - 1 - 8 * TYPE_OFS;
    localparam int TI_MSB         = SHADOW_W - 1 - 8 * TI_OFS;
    localparam int TP_MSB         = SHADOW_W - 1 - 8 * TP_OFS;
    localparam int TBLANK1_MSB    = SHADOW_W - 1 - 8 * TBLANK1_OFS;
    localparam int TBLANK2_MSB    = SHADOW_W - 1 - 8 * TBLANK2_OFS;

    typedef struct packed {
        logic [FREQ_W-1:0]       freq;
        logic [FREQ_STEP_W-1:0]  freq_step;
        logic [FREQ_RATE_W-1:0]  freq_rate;
        logic [TIME_START_W-1:0] time_start;
        logic [N_IMPULSE_W-1:0]  n_impulse;
        logic [TYPE_W-1:0]       type_impulse;
        logic [INTERVAL_W-1:0]   interval_ti;
        logic [INTERVAL_W-1:0]   interval_tp;
        logic [TBLANK_W-1:0]     tblank1;
        logic [TBLANK_W-1:0]     tblank2;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CKSUM   = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte idle counter. Clear restarts the count; while enabled and not
// cleared it counts idle cycles and flags the LIMIT-th one as expired.
module frame_timeout #(
    parameter int LIMIT = 4800
) (
    input  logic clk_48,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count idle cycles, holding at the terminal value so it never wraps
    always_ff @(posedge clk_48) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The idle cycle that starts with the count at LAST is the LIMIT-th one
    assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/cmd_frame_packer.sv
// Validates a fixed-length command frame (header, 43 payload bytes,
// checksum) from the SPI byte stream and commits it to the wcm fields.
//
// Byte interface: DIN is consumed in every cycle DIN_VALID is high (at most
// one byte per cycle); there is no ready, the packer never back-pressures.
module cmd_frame_packer
    import cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 4800,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    FRAME_START,
    input  logic [7:0]              DIN,
    input  logic                    DIN_VALID,
    output logic [FREQ_W-1:0]       FREQ,
    output logic [FREQ_STEP_W-1:0]  FREQ_STEP,
    output logic [FREQ_RATE_W-1:0]  FREQ_RATE,
    output logic [TIME_START_W-1:0] TIME_START,
    output logic [N_IMPULSE_W-1:0]  N_impulse,
    output logic [TYPE_W-1:0]       TYPE_impulse,
    output logic [INTERVAL_W-1:0]   Interval_Ti,
    output logic [INTERVAL_W-1:0]   Interval_Tp,
    output logic [TBLANK_W-1:0]     Tblank1,
    output logic [TBLANK_W-1:0]     Tblank2,
    output logic                    WR,
    output logic                    ERR_SUM,
    output logic                    ERR_TMO,
    output logic                    BUSY,
    output logic [FRAME_CNT_W-1:0]  FRAME_CNT,
    output state_t                  STATE_DBG
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(PAYLOAD_BYTES - 1);

    state_t                 state_q, state_d;
    logic [SHADOW_W-1:0]    shadow_q;
    logic [SUM_W-1:0]       sum_q;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q;
    cmd_t                   cmd_q, shadow_cmd;
    logic                   wr_q, err_sum_q, err_tmo_q, busy_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic tmo_en, tmo_clr, tmo_expired;
    logic start_payload, shift_en, commit_go;
    logic err_sum_d, err_tmo_d, busy_d;
    logic unused_type_rsvd;

    // Timeout only guards the body of a frame; any byte or restart clears it
    assign tmo_en  = (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);
    assign tmo_clr = DIN_VALID || FRAME_START || !tmo_en;

    frame_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk_48  (CLK),
        .rst     (RESET),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Field view of the shadow register; upper six bits of the TYPE byte are dropped
    always_comb begin
        shadow_cmd              = '0;
        shadow_cmd.freq         = shadow_q[FREQ_MSB -: FREQ_W];
        shadow_cmd.freq_step    = shadow_q[FREQ_STEP_MSB -: FREQ_STEP_W];
        shadow_cmd.freq_rate    = shadow_q[FREQ_RATE_MSB -: FREQ_RATE_W];
        shadow_cmd.time_start   = shadow_q[TIME_START_MSB -: TIME_START_W];
        shadow_cmd.n_impulse    = shadow_q[N_IMPULSE_MSB -: N_IMPULSE_W];
        shadow_cmd.type_impulse = shadow_q[TYPE_MSB - 6 -: TYPE_W];
        shadow_cmd.interval_ti  = shadow_q[TI_MSB -: INTERVAL_W];
        shadow_cmd.interval_tp  = shadow_q[TP_MSB -: INTERVAL_W];
        shadow_cmd.tblank1      = shadow_q[TBLANK1_MSB -: TBLANK_W];
        shadow_cmd.tblank2      = shadow_q[TBLANK2_MSB -: TBLANK_W];
    end

    assign unused_type_rsvd = ^shadow_q[TYPE_MSB -: 6];

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; FRAME_START always wins and restarts at the header
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (FRAME_START) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (FRAME_START)    state_d = ST_HDR;
                else if (DIN_VALID) state_d = (DIN == HDR_BYTE) ? ST_PAYLOAD : ST_IDLE;
            end
            ST_PAYLOAD: begin
                if (FRAME_START)                             state_d = ST_HDR;
                else if (tmo_expired)                        state_d = ST_IDLE;
                else if (DIN_VALID && byte_cnt_q == LAST_IDX) state_d = ST_CKSUM;
            end
            ST_CKSUM: begin
                if (FRAME_START)      state_d = ST_HDR;
                else if (tmo_expired) state_d = ST_IDLE;
                else if (DIN_VALID)   state_d = (DIN == sum_q) ? ST_COMMIT : ST_IDLE;
            end
            ST_COMMIT: begin
                state_d = FRAME_START ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: datapath enables and next values of the registered strobes
    always_comb begin
        start_payload = (state_q == ST_HDR) && !FRAME_START && DIN_VALID && (DIN == HDR_BYTE);
        shift_en      = (state_q == ST_PAYLOAD) && !FRAME_START && DIN_VALID;
        commit_go     = (state_q == ST_CKSUM) && !FRAME_START && DIN_VALID && (DIN == sum_q);
        err_sum_d     = (state_q == ST_CKSUM) && !FRAME_START && DIN_VALID && (DIN != sum_q);
        err_tmo_d     = tmo_expired ||
                        (FRAME_START && ((state_q == ST_HDR) || (state_q == ST_PAYLOAD) ||
                                         (state_q == ST_CKSUM)));
        busy_d        = (state_d == ST_PAYLOAD) || (state_d == ST_CKSUM) ||
                        (state_d == ST_COMMIT);
    end

    // Shadow capture, checksum accumulation, commit of fields and strobes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_q    <= '0;
            sum_q       <= '0;
            byte_cnt_q  <= '0;
            cmd_q       <= '0;
            frame_cnt_q <= '0;
            wr_q        <= 1'b0;
            err_sum_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_q      <= commit_go;
            err_sum_q <= err_sum_d;
            err_tmo_q <= err_tmo_d;
            busy_q    <= busy_d;
            if (start_payload) begin
                sum_q      <= '0;
                byte_cnt_q <= '0;
            end
            if (shift_en) begin
                shadow_q   <= {shadow_q[SHADOW_W-9:0], DIN};
                sum_q      <= sum_q + DIN;
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (commit_go) begin
                cmd_q       <= shadow_cmd;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign FREQ         = cmd_q.freq;
    assign FREQ_STEP    = cmd_q.freq_step;
    assign FREQ_RATE    = cmd_q.freq_rate;
    assign TIME_START   = cmd_q.time_start;
    assign N_impulse    = cmd_q.n_impulse;
    assign TYPE_impulse = cmd_q.type_impulse;
    assign Interval_Ti  = cmd_q.interval_ti;
    assign Interval_Tp  = cmd_q.interval_tp;
    assign Tblank1      = cmd_q.tblank1;
    assign Tblank2      = cmd_q.tblank2;
    assign WR           = wr_q;
    assign ERR_SUM      = err_sum_q;
    assign ERR_TMO      = err_tmo_q;
    assign BUSY         = busy_q;
    assign FRAME_CNT    = frame_cnt_q;
    assign STATE_DBG    = state_q;

endmodule

// File: tb/tb_cmd_frame_packer.sv
// Bench for cmd_frame_packer: table of frames, hand-written multi-cycle
// sequences, and random frames checked against a byte-level frame model.
module tb_cmd_frame_packer;
    import cmd_pkg::*;

    localparam int         TMO = 4800;
    localparam logic [7:0] HDR = 8'hA5;
    localparam int         FW  = 338;
    localparam int         EW  = FW + 16;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    always #10 CLK = ~CLK;

    logic RESET = 1'b1, FRAME_START = 1'b0, DIN_VALID = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [47:0] FREQ, FREQ_STEP;
    logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse, FRAME_CNT;
    logic [1:0]  TYPE_impulse;
    logic WR, ERR_SUM, ERR_TMO, BUSY;
    state_t STATE_DBG;

    cmd_frame_packer #(.TIMEOUT_CYC(TMO), .HDR_BYTE(HDR)) dut (
        .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .FREQ(FREQ), .FREQ_STEP(FREQ_STEP), .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START),
        .N_impulse(N_impulse), .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti),
        .Interval_Tp(Interval_Tp), .Tblank1(Tblank1), .Tblank2(Tblank2), .WR(WR),
        .ERR_SUM(ERR_SUM), .ERR_TMO(ERR_TMO), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT),
        .STATE_DBG(STATE_DBG)
    );

    // ---------------- scoreboard state ----------------
    int total = 0, bad = 0;
    int wr_cnt = 0, esum_cnt = 0, etmo_cnt = 0;
    bit busy_seen = 1'b0;
    logic [EW-1:0] exp_q[$];
    logic [FW-1:0] last_fields = '0;
    logic [15:0]   model_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] out_fields();
        return {FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
                Interval_Ti, Interval_Tp, Tblank1, Tblank2};
    endfunction

    // Monitor: count strobes, compare every commit with the next expected one
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (BUSY) busy_seen = 1'b1;
        if (ERR_SUM) esum_cnt++;
        if (ERR_TMO) etmo_cnt++;
        if (WR) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr: got WR=1 expected no commit");
            end else begin
                e = exp_q.pop_front();
                check_wide("commit_fields", out_fields(), e[FW-1:0]);
                check("commit_frame_cnt", 64'(FRAME_CNT), 64'(e[EW-1:FW]));
            end
        end
    end

    // ---------------- reference model ----------------
    // Fields from the raw payload bytes: big-endian, in layout order, TYPE keeps 2 bits
    function automatic logic [FW-1:0] model_from_bytes(input logic [7:0] b [43]);
        int lens [10] = '{6, 6, 4, 8, 2, 1, 4, 4, 4, 4};
        logic [FW-1:0] r = '0;
        logic [63:0] v;
        int k = 0;
        for (int f = 0; f < 10; f++) begin
            v = '0;
            for (int j = 0; j < lens[f]; j++) begin
                v = (v << 8) | 64'(b[k]);
                k++;
            end
            if (f == 5) r = (r << 2) | FW'(v & 64'h3);
            else        r = (r << (8 * lens[f])) | FW'(v);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        DIN = b;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
        DIN = 8'h00;
    endtask

    task automatic pulse_fs();
        FRAME_START = 1'b1;
        step();
        FRAME_START = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        exp_q.delete();
        last_fields = '0;
        model_cnt = '0;
        step();
    endtask

    // Full frame: FRAME_START, header, payload (random gaps, optional long gap
    // after payload byte long_idx), checksum + cdelta. Model updated on the way.
    task automatic run_frame(input logic [343:0] pl, input logic [7:0] hdr, input logic [7:0] cdelta,
                             input int gap_max, input int long_idx, input int long_len,
                             input bit tail_wait);
        logic [7:0] b [43];
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 43; i++) begin
            b[i] = pl[343 - 8 * i -: 8];
            s = s + b[i];
        end
        pulse_fs();
        send_byte(hdr);
        for (int i = 0; i < 43; i++) begin
            send_byte(b[i]);
            repeat ($urandom_range(0, gap_max)) step();
            if (i == long_idx) repeat (long_len) step();
        end
        send_byte(s + cdelta);
        if (hdr == HDR && cdelta == 8'h00) begin
            model_cnt = model_cnt + 1'b1;
            last_fields = model_from_bytes(b);
            exp_q.push_back({model_cnt, last_fields});
        end
        if (tail_wait) repeat (3) step();
    endtask

    function automatic logic [343:0] rand_payload();
        logic [343:0] p = '0;
        for (int i = 0; i < 43; i++) p = (p << 8) | 344'($urandom_range(0, 255));
        return p;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [47:0] freq, step_f;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [7:0]  typ;
        logic [31:0] ti, tp, tb1, tb2;
        logic [7:0]  hdr, cdelta;
        int          exp_wr, exp_esum;
        bit          exp_busy;
    } vec_t;

    function automatic logic [343:0] vec_payload(input vec_t v);
        return {v.freq, v.step_f, v.rate, v.tstart, v.n, v.typ, v.ti, v.tp, v.tb1, v.tb2};
    endfunction

    function automatic logic [FW-1:0] vec_fields(input vec_t v);
        return {v.freq, v.step_f, v.rate, v.tstart, v.n, v.typ[1:0], v.ti, v.tp, v.tb1, v.tb2};
    endfunction

    vec_t tbl [6];
    vec_t good;

    initial begin
        int w0, s0, t0, n;
        logic [FW-1:0] f_before;
        logic [343:0] p, p2;

        good = '{48'h001000000000, 48'h000000100000, 32'h100, 64'h12C0, 16'd2, 8'd1,
                 32'h1800, 32'h1800, 32'h180, 32'h180, HDR, 8'h00, 1, 0, 1'b1};
        tbl[0] = good;
        tbl[1] = good; tbl[1].cdelta = 8'h01; tbl[1].exp_wr = 0; tbl[1].exp_esum = 1;
        tbl[2] = good; tbl[2].hdr = 8'h5A; tbl[2].exp_wr = 0; tbl[2].exp_busy = 1'b0;
        tbl[3] = '{'1, '1, '1, '1, '1, 8'hFF, '1, '1, '1, '1, HDR, 8'h00, 1, 0, 1'b1};
        tbl[4] = '{'0, '0, '0, '0, '0, 8'h00, '0, '0, '0, '0, HDR, 8'h00, 1, 0, 1'b1};
        tbl[5] = '{48'h123456789ABC, 48'hFEDCBA987654, 32'hDEADBEEF, 64'h0011223344556677,
                   16'hBEEF, 8'hFE, 32'h01020304, 32'hA0B0C0D0, 32'h55AA55AA, 32'h0F0F0F0F,
                   HDR, 8'h80, 0, 1, 1'b1};

        // Reset state
        do_reset();
        check_wide("reset_fields", out_fields(), '0);
        check("reset_frame_cnt", 64'(FRAME_CNT), 0);
        check("reset_strobes", {WR, ERR_SUM, ERR_TMO, BUSY}, 0);
        check("reset_state", 64'(STATE_DBG), 64'(ST_IDLE));

        // Table-driven frames
        for (int r = 0; r < 6; r++) begin
            w0 = wr_cnt; s0 = esum_cnt; t0 = etmo_cnt;
            f_before = out_fields();
            busy_seen = 1'b0;
            run_frame(vec_payload(tbl[r]), tbl[r].hdr, tbl[r].cdelta, r % 3, -1, 0, 1'b1);
            check("tbl_wr_pulses", 64'(wr_cnt - w0), 64'(tbl[r].exp_wr));
            check("tbl_err_sum", 64'(esum_cnt - s0), 64'(tbl[r].exp_esum));
            check("tbl_err_tmo", 64'(etmo_cnt - t0), 0);
            check("tbl_busy_seen", 64'(busy_seen), 64'(tbl[r].exp_busy));
            check_wide("tbl_fields", out_fields(), tbl[r].exp_wr != 0 ? vec_fields(tbl[r]) : f_before);
            check("tbl_frame_cnt", 64'(FRAME_CNT), 64'(model_cnt));
        end

        // Timeout: 4800 idle cycles after payload byte 20
        t0 = etmo_cnt; w0 = wr_cnt;
        p = rand_payload();
        pulse_fs();
        send_byte(HDR);
        for (int i = 0; i <= 20; i++) send_byte(p[343 - 8 * i -: 8]);
        n = 0;
        while (etmo_cnt == t0 && n < TMO + 20) begin
            step();
            n++;
        end
        check("tmo_latency", 64'(n), 64'(TMO + 1));
        check("tmo_pulses", 64'(etmo_cnt - t0), 1);
        step();
        check("tmo_state_idle", 64'(STATE_DBG), 64'(ST_IDLE));
        check("tmo_busy", 64'(BUSY), 0);
        // One cycle short of the limit must not abort
        t0 = etmo_cnt;
        run_frame(rand_payload(), HDR, 8'h00, 0, 20, TMO - 1, 1'b1);
        check("tmo_edge_no_err", 64'(etmo_cnt - t0), 0);
        check("tmo_edge_wr", 64'(wr_cnt - w0), 1);
        run_frame(vec_payload(good), HDR, 8'h00, 1, -1, 0, 1'b1);
        check("tmo_after_wr", 64'(wr_cnt - w0), 2);
        check_wide("tmo_after_fields", out_fields(), vec_fields(good));

        // FRAME_START after payload byte 10, then a full good frame
        t0 = etmo_cnt; w0 = wr_cnt;
        pulse_fs();
        send_byte(HDR);
        for (int i = 0; i <= 10; i++) send_byte(8'h33);
        p2 = rand_payload();
        run_frame(p2, HDR, 8'h00, 0, -1, 0, 1'b1);
        check("abort_err_tmo", 64'(etmo_cnt - t0), 1);
        check("abort_wr", 64'(wr_cnt - w0), 1);
        check_wide("abort_fields", out_fields(), last_fields);

        // FRAME_START while waiting for the header also aborts
        t0 = etmo_cnt;
        pulse_fs();
        pulse_fs();
        send_byte(8'h00);
        repeat (2) step();
        check("hdr_restart_err", 64'(etmo_cnt - t0), 1);

        // Back-to-back: next FRAME_START in the cycle after the checksum byte
        w0 = wr_cnt; s0 = esum_cnt; t0 = etmo_cnt;
        run_frame(rand_payload(), HDR, 8'h00, 0, -1, 0, 1'b0);
        run_frame(rand_payload(), HDR, 8'h00, 0, -1, 0, 1'b1);
        check("b2b_wr", 64'(wr_cnt - w0), 2);
        check("b2b_errs", 64'(esum_cnt - s0 + etmo_cnt - t0), 0);

        // RESET in the middle of a payload
        pulse_fs();
        send_byte(HDR);
        for (int i = 0; i < 15; i++) send_byte(8'h5C);
        do_reset();
        check_wide("rst_mid_fields", out_fields(), '0);
        check("rst_mid_cnt", 64'(FRAME_CNT), 0);
        check("rst_mid_state", 64'(STATE_DBG), 64'(ST_IDLE));
        check("rst_mid_busy", 64'(BUSY), 0);
        w0 = wr_cnt;
        run_frame(vec_payload(good), HDR, 8'h00, 0, -1, 0, 1'b1);
        check("rst_next_wr", 64'(wr_cnt - w0), 1);
        check("rst_next_cnt", 64'(FRAME_CNT), 1);

        // Random frames: random data, gaps, checksum corruption and bad headers
        for (int r = 0; r < 40; r++) begin
            logic [7:0] hdr, cd;
            int exp_w, exp_s;
            w0 = wr_cnt; s0 = esum_cnt;
            hdr = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : HDR;
            cd  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            exp_w = (hdr == HDR && cd == 8'h00) ? 1 : 0;
            exp_s = (hdr == HDR && cd != 8'h00) ? 1 : 0;
            f_before = last_fields;
            run_frame(rand_payload(), hdr, cd, 2, -1, 0, 1'b1);
            check("rnd_wr", 64'(wr_cnt - w0), 64'(exp_w));
            check("rnd_err_sum", 64'(esum_cnt - s0), 64'(exp_s));
            if (exp_w == 0) check_wide("rnd_hold", out_fields(), f_before);
        end

        repeat (3) step();
        check("pending_commits", 64'(exp_q.size()), 0);
        check("final_frame_cnt", 64'(FRAME_CNT), 64'(model_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_frame_packer.md
# cmd_frame_packer

Upstream feeder for the real-time command register (wcm). Receives the byte stream delivered by the MCU SPI slave, validates a fixed-length command frame (header, 43 payload bytes, checksum) and unpacks it into the wcm command fields. Finished fields are presented with a one-cycle `WR` pulse that drives wcm's `WR` input. Runs in the 48 MHz synchronizer domain.

## Interface
- `TIMEOUT_CYC`, default 4800: maximum idle cycles between bytes inside a frame (100 µs at 48 MHz).
- `HDR_BYTE`, default 8'hA5: frame start marker.
- `CLK` in 1: 48 MHz clock.
- `RESET` in 1: reset; one clock, synchronous and active-high.
- `FRAME_START` in 1: one-cycle pulse on SPI CS assertion. Aborts any frame in progress.
- `DIN` in 8: received byte.
- `DIN_VALID` in 1: `DIN` is valid this cycle. At most one byte per cycle.
- `FREQ` out 48: command field.
- `FREQ_STEP` out 48: command field.
- `FREQ_RATE` out 32: command field.
- `TIME_START` out 64: command field.
- `N_impulse` out 16: command field.
- `TYPE_impulse` out 2: command field.
- `Interval_Ti` out 32: command field.
- `Interval_Tp` out 32: command field.
- `Tblank1` out 32: command field.
- `Tblank2` out 32: command field.
- `WR` out 1: one-cycle commit strobe to wcm.
- `ERR_SUM` out 1: one-cycle pulse; checksum mismatch.
- `ERR_TMO` out 1: one-cycle pulse; inter-byte timeout or `FRAME_START` during a frame.
- `BUSY` out 1: high while a frame is being received.
- `FRAME_CNT` out 16: count of committed frames; wraps at 0xFFFF→0.

## Operation
- Frame layout: `HDR_BYTE`, then 43 payload bytes, then 1 checksum byte. All fields are big-endian, MSB byte first, in this order:
  - FREQ 6 bytes, FREQ_STEP 6, FREQ_RATE 4, TIME_START 8
  - N_impulse 2, TYPE 1 (bits [1:0] used, [7:2] ignored but summed)
  - Ti 4, Tp 4, Tblank1 4, Tblank2 4
- Checksum: the 8-bit sum mod 256 of all 43 payload bytes. The header is excluded.
- FSM states:
  - IDLE: waits for `FRAME_START`; → HDR.
  - HDR: a valid byte equal to `HDR_BYTE` → PAYLOAD with `byte_cnt`=0. Any other byte → IDLE with no error.
  - PAYLOAD: each valid byte is shifted into a 344-bit shadow register and added to `sum`; `byte_cnt`++. The 43rd byte → CKSUM.
  - CKSUM: byte == `sum` → COMMIT. Otherwise `ERR_SUM` pulses → IDLE.
  - COMMIT: shadow is copied to the field outputs, `WR`=1 and `FRAME_CNT`++ → IDLE (one cycle).
- Output fields change only in COMMIT and otherwise hold the last committed frame. Shadow contents never reach the outputs directly.
- `FRAME_START` in HDR/PAYLOAD/CKSUM: `ERR_TMO` pulses and the frame restarts in HDR. `FRAME_START` in IDLE or COMMIT → HDR, no error. `FRAME_START` arriving in COMMIT does not suppress the commit.
- Timeout counter: cleared on every valid byte. In PAYLOAD/CKSUM, reaching `TIMEOUT_CYC` → `ERR_TMO`, IDLE. No timeout applies in IDLE/HDR.
- Bytes after the checksum byte, before the next `FRAME_START`, are ignored.
- `BUSY` = state ∈ {PAYLOAD, CKSUM, COMMIT}.

## Timing
- Reset values:
  - All fields, `FRAME_CNT`, `sum`, `byte_cnt` = 0.
  - `WR`, `ERR_SUM`, `ERR_TMO`, `BUSY` = 0.
  - State = IDLE.
- All outputs are registered.
- `WR` and the new field values appear together, one cycle after the cycle in which the checksum byte is sampled.
- `ERR_SUM` appears one cycle after the bad checksum byte is sampled. `ERR_TMO` appears one cycle after the abort condition.
- `RESET` mid-frame discards the shadow. Outputs return to 0, not to the last frame.
- Back-to-back frames: a new `FRAME_START` may arrive in the cycle after the checksum byte.

## Structure
- Shared package `cmd_pkg` holds:
  - Field width constants and `PAYLOAD_BYTES`=43.
  - Byte offsets of each field within the payload.
  - The `cmd_t` packed struct of all ten fields.
  - The FSM state enum.
- The same `cmd_t` is reused by wcm.
- Sub-module `frame_timeout` (counter with clear/enable/expire) is natural; everything else stays flat.

## Test plan
- Good frame carrying FREQ=0x001000000000, FREQ_STEP=0x000000100000, FREQ_RATE=0x100, TIME_START=0x12C0, N=2, TYPE=1, Ti=Tp=0x1800, Tblank1=Tblank2=0x180, correct checksum → one `WR` pulse, all fields equal these values, `FRAME_CNT`=1.
- Same frame with checksum+1 → `ERR_SUM` pulse, no `WR`, fields unchanged, `FRAME_CNT` unchanged.
- Gap of 4800 idle cycles after payload byte 20 → `ERR_TMO`. A following good frame commits normally.
- `FRAME_START` after payload byte 10, followed by a full good frame → one `ERR_TMO`, then one `WR` carrying the second frame's data.
- First byte 0x5A instead of 0xA5 → no `WR`, no error, `BUSY` stays 0.
- `RESET` asserted during PAYLOAD → outputs zero, state IDLE. The next good frame commits.
